// File: rtl/ddr_xfer_scheduler_pkg.sv
// Shared types and constants for the DDR transfer scheduler and its arbiter.
package ddr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        RETRY  = 3'd4
    } sched_state_e;

    localparam int LAUNCH_CYCLES = 2;
    localparam int BASE_W        = 8;
    localparam int IDX_W         = 3;

endpackage

// File: rtl/ddr_xfer_scheduler_rr_arbiter.sv
// Rotating-priority pick: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter
    import ddr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    logic [2*NUM_REQ-1:0] rotated;
    logic [IDX_W:0]       pos;

    always_comb begin
        // Doubling the vector lets a plain shift implement the wrap-around.
        rotated   = {req_valid, req_valid} >> rr_ptr;
        pos       = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                pos   = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
                if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                    pos = pos - (IDX_W + 1)'(NUM_REQ);
                end
                grant_idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ddr_xfer_scheduler.sv
// Serialises BRAM<->DDR transfers through one interface: round-robin grant, launch, watchdog, retry.
module ddr_xfer_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                   clk_100,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*8-1:0]   req_base,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [2:0]             bank_sel,
    output logic                   iface_rst,
    output logic                   iface_read_write,
    output logic [7:0]             iface_base,
    input  logic                   iface_done,
    output logic                   busy
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] r;
        for (int k = 0; k < NUM_REQ; k++) begin
            r[k] = (i == IDX_W'(k));
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    sched_state_e          state_q, state_d;
    logic [1:0]            launch_cnt_q, launch_cnt_d;
    logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
    logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      bank_sel_q, bank_sel_d;
    logic                  iface_rw_q, iface_rw_d;
    logic [BASE_W-1:0]     iface_base_q, iface_base_d;
    logic                  iface_rst_q, iface_rst_d;
    logic [NUM_REQ-1:0]    req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0]    req_done_q, req_done_d;
    logic [NUM_REQ-1:0]    req_err_q, req_err_d;
    logic                  busy_q, busy_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic                  pick_write;
    logic [BASE_W-1:0]     pick_base;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        pick_write = 1'b0;
        pick_base  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_write = req_write[k];
                pick_base  = req_base[k*BASE_W +: BASE_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        launch_cnt_d = launch_cnt_q;
        wdog_d       = wdog_q;
        retry_cnt_d  = retry_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        bank_sel_d   = bank_sel_q;
        iface_rw_d   = iface_rw_q;
        iface_base_d = iface_base_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    bank_sel_d   = pick_idx;
                    iface_rw_d   = pick_write;
                    iface_base_d = pick_base;
                    launch_cnt_d = '0;
                    wdog_d       = '0;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                if (launch_cnt_q == 2'(LAUNCH_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    launch_cnt_d = launch_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // Leaving on the incremented value gives exactly 2^TIMEOUT_W-1 RUN cycles.
                wdog_d = wdog_q + 1'b1;
                if (iface_done) begin
                    state_d = FINISH;
                end else if (&wdog_d) begin
                    state_d = RETRY;
                end
            end
            FINISH: begin
                retry_cnt_d = '0;
                rr_ptr_d    = next_ptr(bank_sel_q);
                state_d     = IDLE;
            end
            RETRY: begin
                if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
                    retry_cnt_d = '0;
                    rr_ptr_d    = next_ptr(bank_sel_q);
                    state_d     = IDLE;
                end else begin
                    retry_cnt_d  = retry_cnt_q + 1'b1;
                    launch_cnt_d = '0;
                    wdog_d       = '0;
                    state_d      = LAUNCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        busy_d      = (state_d != IDLE);
        iface_rst_d = (state_d != RUN);
        req_grant_d = (state_d != IDLE) ? idx_onehot(bank_sel_d) : '0;
        req_done_d  = (state_d == FINISH) ? idx_onehot(bank_sel_d) : '0;
        req_err_d   = (state_d == RETRY && retry_cnt_q == RETRY_W'(MAX_RETRY))
                      ? idx_onehot(bank_sel_d) : '0;
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state_q      <= IDLE;
            launch_cnt_q <= '0;
            wdog_q       <= '0;
            retry_cnt_q  <= '0;
            rr_ptr_q     <= '0;
            bank_sel_q   <= '0;
            iface_rw_q   <= 1'b0;
            iface_base_q <= '0;
            iface_rst_q  <= 1'b1;
            req_grant_q  <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            launch_cnt_q <= launch_cnt_d;
            wdog_q       <= wdog_d;
            retry_cnt_q  <= retry_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            bank_sel_q   <= bank_sel_d;
            iface_rw_q   <= iface_rw_d;
            iface_base_q <= iface_base_d;
            iface_rst_q  <= iface_rst_d;
            req_grant_q  <= req_grant_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_grant        = req_grant_q;
    assign req_done         = req_done_q;
    assign req_err          = req_err_q;
    assign bank_sel         = bank_sel_q;
    assign iface_rst        = iface_rst_q;
    assign iface_read_write = iface_rw_q;
    assign iface_base       = iface_base_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_ddr_xfer_scheduler.sv
// Directed bench: instance a (default watchdog) for normal traffic, instance b (TIMEOUT_W=6) for retries.
module tb_ddr_xfer_scheduler;

    localparam int N = 4;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic rst;

    logic [N-1:0]   a_valid, a_write, a_grant, a_done, a_err;
    logic [N*8-1:0] a_base;
    logic [2:0]     a_bank;
    logic           a_irst, a_rw, a_idone, a_busy;
    logic [7:0]     a_ibase;

    logic [N-1:0]   b_valid, b_write, b_grant, b_done, b_err;
    logic [N*8-1:0] b_base;
    logic [2:0]     b_bank;
    logic           b_irst, b_rw, b_idone, b_busy;
    logic [7:0]     b_ibase;

    int a_delay = -1;
    int b_delay = -1;
    int a_cnt   = 0;
    int b_cnt   = 0;

    int passed = 0;
    int total  = 0;

    ddr_xfer_scheduler #(.NUM_REQ(N), .TIMEOUT_W(16), .MAX_RETRY(2)) dut_a (
        .clk_100(clk_100), .rst(rst),
        .req_valid(a_valid), .req_write(a_write), .req_base(a_base),
        .req_grant(a_grant), .req_done(a_done), .req_err(a_err),
        .bank_sel(a_bank), .iface_rst(a_irst), .iface_read_write(a_rw),
        .iface_base(a_ibase), .iface_done(a_idone), .busy(a_busy)
    );

    ddr_xfer_scheduler #(.NUM_REQ(N), .TIMEOUT_W(6), .MAX_RETRY(2)) dut_b (
        .clk_100(clk_100), .rst(rst),
        .req_valid(b_valid), .req_write(b_write), .req_base(b_base),
        .req_grant(b_grant), .req_done(b_done), .req_err(b_err),
        .bank_sel(b_bank), .iface_rst(b_irst), .iface_read_write(b_rw),
        .iface_base(b_ibase), .iface_done(b_idone), .busy(b_busy)
    );

    // Interface models: done rises <delay> cycles after reset falls and holds until reset; -1 = never.
    always @(posedge clk_100) begin
        if (a_irst) begin
            a_cnt   <= 0;
            a_idone <= 1'b0;
        end else begin
            a_cnt <= a_cnt + 1;
            if (a_delay >= 0 && a_cnt >= a_delay) a_idone <= 1'b1;
        end
    end

    always @(posedge clk_100) begin
        if (b_irst) begin
            b_cnt   <= 0;
            b_idone <= 1'b0;
        end else begin
            b_cnt <= b_cnt + 1;
            if (b_delay >= 0 && b_cnt >= b_delay) b_idone <= 1'b1;
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [31:0] base;
        int          delay;
        int          exp_idx;
        logic        exp_rw;
        logic [7:0]  exp_base;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        int   n;
        logic prev;
        a_delay = v.delay;
        a_valid = v.valid;
        a_write = v.write;
        a_base  = v.base;
        n = 0;
        while (!a_busy && n < 8) begin tick(); n++; end
        chk($sformatf("v%0d launch_lat", k), n, 1);
        chk($sformatf("v%0d grant", k), a_grant, oh(v.exp_idx));
        chk($sformatf("v%0d bank_sel", k), a_bank, v.exp_idx);
        chk($sformatf("v%0d iface_base", k), a_ibase, v.exp_base);
        chk($sformatf("v%0d iface_rw", k), a_rw, v.exp_rw);
        n = 0;
        while (a_irst && n < 8) begin tick(); n++; end
        chk($sformatf("v%0d run_lat", k), n, 2);
        prev = 1'b0;
        n = 0;
        while (a_done == '0 && n < v.delay + 50) begin prev = a_idone; tick(); n++; end
        chk($sformatf("v%0d req_done", k), a_done, oh(v.exp_idx));
        chk($sformatf("v%0d done_after_iface", k), prev, 1);
        chk($sformatf("v%0d rst_at_done", k), a_irst, 1);
        chk($sformatf("v%0d bank_stable", k), a_bank, v.exp_idx);
        tick();
        chk($sformatf("v%0d done_width", k), a_done, 0);
        chk($sformatf("v%0d idle", k), a_busy, 0);
    endtask

    task automatic run_timeout(input logic [3:0] mask, input int idx, input logic [7:0] ebase,
                               input string tag);
        int   attempts = 0;
        int   runlen[4] = '{default: 0};
        logic prev_rst;
        logic seen_done = 1'b0;
        int   n = 0;
        b_delay  = -1;
        b_valid  = mask;
        b_write  = 4'b0000;
        b_base   = 32'hD4C3_B2A1;
        prev_rst = b_irst;
        while (b_err == '0 && n < 600) begin
            tick();
            n++;
            if (!b_irst && prev_rst) attempts++;
            if (!b_irst && attempts >= 1 && attempts <= 4) runlen[attempts-1]++;
            seen_done = seen_done | (|b_done);
            prev_rst = b_irst;
        end
        b_valid = '0;
        chk({tag, " attempts"}, attempts, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("%s run%0d_len", tag, i), runlen[i], 63);
        chk({tag, " req_err"}, b_err, mask);
        chk({tag, " no_done"}, seen_done, 0);
        chk({tag, " bank_sel"}, b_bank, idx);
        chk({tag, " iface_base"}, b_ibase, ebase);
        chk({tag, " iface_rw"}, b_rw, 0);
        tick();
        chk({tag, " err_width"}, b_err, 0);
        chk({tag, " idle"}, b_busy, 0);
    endtask

    initial begin
        int   n;
        logic stray;

        vecs[0] = '{4'b0001, 4'b0001, 32'h0000_002A, 600, 0, 1'b1, 8'h2A};
        vecs[1] = '{4'b1111, 4'b1010, 32'h4433_2211, 10, 1, 1'b1, 8'h22};
        vecs[2] = '{4'b1111, 4'b1010, 32'h4433_2211, 10, 2, 1'b0, 8'h33};
        vecs[3] = '{4'b1111, 4'b1010, 32'h4433_2211, 10, 3, 1'b1, 8'h44};
        vecs[4] = '{4'b1111, 4'b1010, 32'h4433_2211, 10, 0, 1'b0, 8'h11};
        vecs[5] = '{4'b1111, 4'b1010, 32'h4433_2211, 10, 1, 1'b1, 8'h22};
        vecs[6] = '{4'b0100, 4'b1010, 32'h4433_2211, 10, 2, 1'b0, 8'h33};
        vecs[7] = '{4'b1001, 4'b1010, 32'h4433_2211, 10, 3, 1'b1, 8'h44};
        vecs[8] = '{4'b0110, 4'b1010, 32'h4433_2211, 10, 1, 1'b1, 8'h22};
        vecs[9] = '{4'b1000, 4'b1010, 32'h4433_2211, 10, 3, 1'b1, 8'h44};

        rst = 1'b1;
        a_valid = '0; a_write = '0; a_base = '0;
        b_valid = '0; b_write = '0; b_base = '0;
        repeat (3) tick();
        chk("rst iface_rst", a_irst, 1);
        chk("rst grant", a_grant, 0);
        chk("rst done", a_done, 0);
        chk("rst err", a_err, 0);
        chk("rst bank_sel", a_bank, 0);
        chk("rst iface_rw", a_rw, 0);
        chk("rst iface_base", a_ibase, 0);
        chk("rst busy", a_busy, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);
        a_valid = '0;
        tick();

        // Reset 50 cycles into RUN.
        a_delay = -1;
        a_valid = 4'b0001; a_write = 4'b0001; a_base = 32'h0000_0077;
        n = 0;
        while (a_irst && n < 10) begin tick(); n++; end
        chk("midrst reached_run", a_irst, 0);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        chk("midrst iface_rst", a_irst, 1);
        chk("midrst grant", a_grant, 0);
        chk("midrst busy", a_busy, 0);
        chk("midrst bank_sel", a_bank, 0);
        chk("midrst iface_base", a_ibase, 0);
        rst = 1'b0;
        a_valid = '0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); stray = stray | (|a_done) | (|a_err); end
        chk("midrst no_pulse", stray, 0);

        // Requester 2 drops valid during RUN; transfer still completes, pointer moves to 3.
        a_delay = 30;
        a_valid = 4'b0100; a_write = 4'b0000; a_base = 32'h4433_2211;
        n = 0;
        while (a_irst && n < 10) begin tick(); n++; end
        repeat (5) tick();
        a_valid = '0;
        n = 0;
        while (a_done == '0 && n < 100) begin tick(); n++; end
        chk("drop req_done", a_done, 4'b0100);
        tick();
        a_valid = 4'b1111;
        n = 0;
        while (!a_busy && n < 8) begin tick(); n++; end
        chk("drop next_grant", a_grant, 4'b1000);
        chk("drop next_bank", a_bank, 3);
        n = 0;
        while (a_done == '0 && n < 100) begin tick(); n++; end
        a_valid = '0;
        tick();

        run_timeout(4'b0010, 1, 8'hB2, "timeout");

        // First attempt hangs, second completes.
        b_delay = -1;
        b_valid = 4'b0010; b_write = 4'b0000; b_base = 32'hD4C3_B2A1;
        n = 0;
        while (b_irst && n < 10) begin tick(); n++; end
        n = 0;
        while (!b_irst && n < 100) begin tick(); n++; end
        chk("recover retry_seen", b_irst, 1);
        b_delay = 5;
        stray = 1'b0;
        n = 0;
        while (b_done == '0 && n < 100) begin tick(); n++; stray = stray | (|b_err); end
        chk("recover req_done", b_done, 4'b0010);
        chk("recover no_err", stray, 0);
        b_valid = '0;
        tick();

        run_timeout(4'b0001, 0, 8'hA1, "after_recover");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ddr_xfer_scheduler.md
# ddr_xfer_scheduler

Sequences polynomial transfers between the BRAM banks and DDR, one transfer at a time, through the single `ddr_iface_100m_pol` instance. Up to NUM_REQ requesters (compute cores / host loader) post load or store requests. The block:
- arbitrates between them round-robin;
- sets the interface's direction and base address, and steers the BRAM bank mux;
- recycles the interface between transfers by pulsing its reset;
- detects a hung transfer with a watchdog and retries it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_W, 16, watchdog counter width
- MAX_RETRY, 2, retries per request before error

Ports:
- clk_100  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request pending; held until req_done
- req_write  in  NUM_REQ  per-requester direction, 1 = BRAM→DDR store, 0 = DDR→BRAM load
- req_base  in  NUM_REQ*8  per-requester DDR base address, slice i = [8i+7:8i]
- req_grant  out  NUM_REQ  one-hot, high while requester is being served
- req_done  out  NUM_REQ  one-cycle pulse, transfer finished OK
- req_err  out  NUM_REQ  one-cycle pulse, transfer abandoned after retries
- bank_sel  out  3  BRAM bank mux select = granted index
- iface_rst  out  1  reset to interface
- iface_read_write  out  1  to interface read_write
- iface_base  out  8  to interface ddr_base_address_in
- iface_done  in  1  interface done
- busy  out  1  state ≠ IDLE

## Operation
States: IDLE, LAUNCH, RUN, FINISH, RETRY.

- **IDLE**
  - iface_rst=1; req_grant=0.
  - If any req_valid: pick the first valid index at or after rr_ptr (wrapping).
  - Latch the index, direction and base into registers; go to LAUNCH.
- **LAUNCH** (2 cycles, counted by launch_cnt)
  - iface_rst=1; iface_read_write, iface_base and bank_sel driven from the latched registers.
  - The interface latches its base address while its reset is high.
  - Then go to RUN.
- **RUN**
  - iface_rst=0; wdog increments every cycle.
  - If iface_done=1: go to FINISH.
  - Else if wdog is all-ones: go to RETRY.
- **FINISH** (1 cycle)
  - Pulse req_done[idx]; iface_rst=1; rr_ptr ← idx+1 mod NUM_REQ; go to IDLE.
- **RETRY** (1 cycle)
  - iface_rst=1; retry_cnt++.
  - If retry_cnt was MAX_RETRY: pulse req_err[idx], clear retry_cnt, advance rr_ptr, go to IDLE.
  - Else: go to LAUNCH with the same latched request.

Additional rules:
- Latched registers, idx and bank_sel stay stable from LAUNCH until the IDLE entry that follows. Later changes on req_* have no effect on the transfer in progress.
- req_grant[idx]=1 in LAUNCH, RUN, FINISH and RETRY.
- retry_cnt clears on every FINISH.
- A req_valid dropped mid-transfer does not abort it. The transfer completes and req_done still pulses.
- The interface's own tag-mismatch restart (done never rises) is covered by the watchdog.

## Timing
- Reset values: iface_rst=1, req_grant=0, req_done=0, req_err=0, bank_sel=0, iface_read_write=0, iface_base=0, busy=0, rr_ptr=0, retry_cnt=0, wdog=0, state IDLE.
- Request latency: req_valid seen in IDLE at cycle t → LAUNCH at t+1, t+2 → iface_rst=0 from t+3.
- Completion: iface_done sampled high at cycle d → req_done pulse at d+1, with iface_rst=1 in the same cycle. The next grant can start LAUNCH at d+3.
- The watchdog is 2^TIMEOUT_W−1 cycles of RUN and is cleared on LAUNCH entry.
- Simultaneous requests: only one grant; the others wait. Fairness is guaranteed, with at most NUM_REQ−1 intervening transfers.
- rst mid-transfer: the cycle after rst, all outputs are at reset values, the interface is held in reset, and no req_done/req_err is emitted.
- All outputs are registered.

## Structure
- Shared package `ddr_sched_pkg`:
  - state enum (IDLE=0, LAUNCH=1, RUN=2, FINISH=3, RETRY=4);
  - LAUNCH_CYCLES=2 constant;
  - base-address width constant 8.
- One sub-module: `rr_arbiter` (NUM_REQ-wide rotating priority pick from req_valid and rr_ptr; combinational index + found flag).
- The FSM, watchdog and latches live in the top.

## Test plan
- **Single store:** req_valid=4'b0001, req_write=1, base 0x2A; the interface model raises done 600 cycles after iface_rst falls → iface_base=0x2A, iface_read_write=1, bank_sel=0; req_done[0] pulses exactly once, 1 cycle after done.
- **Round-robin:** req_valid=4'b1111 held, done after 10 cycles each → grant order 0,1,2,3,0; bank_sel tracks the granted index.
- **Timeout/retry:** TIMEOUT_W=6, the model never asserts done, MAX_RETRY=2 → three LAUNCH/RUN attempts, each RUN 63 cycles; req_err[idx] pulses once; no req_done.
- **Recovery after retry:** done withheld on the first attempt, asserted on the second → req_done pulses; retry_cnt is 0 afterwards; the next request is unaffected.
- **Reset mid-RUN:** assert rst 50 cycles into RUN → the next cycle iface_rst=1, req_grant=0, busy=0; no req_done pulse.
- **Request dropped mid-transfer:** deassert req_valid[2] during RUN → the transfer completes and req_done[2] pulses; rr_ptr=3.
